// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy level, almost-full/almost-empty flags,
// synchronous flush and valid/ready handshakes on both sides. Any DEPTH >= 2 is
// supported; pointers wrap explicitly rather than relying on binary overflow.
//
// Optional feature macro: SYNC_FIFO_PASSTHROUGH_EN
//   When defined and the FIFO is empty (and not flushing), the write side is
//   presented combinationally on the read side. A word offered and taken in the
//   same cycle is never stored.
//
// Ports:
//   clk          in   clock, all state updates on the rising edge
//   rstn         in   asynchronous active-low reset
//   flush        in   synchronous discard of all contents
//   w_valid      in   write request
//   w_ready      out  FIFO can accept a write
//   w_data       in   write payload (TYPE)
//   r_valid      out  r_data holds the head entry
//   r_ready      in   consumer accepts the head entry
//   r_data       out  head entry (TYPE)
//   level        out  number of stored entries
//   almost_full  out  level >= ALMOST_FULL
//   almost_empty out  level <= ALMOST_EMPTY
module sync_fifo #(
  parameter int  DATA_WIDTH   = 1,
  parameter type TYPE         = logic [DATA_WIDTH-1:0],
  parameter int  DEPTH        = 2,
  parameter int  ALMOST_FULL  = DEPTH - 1,
  parameter int  ALMOST_EMPTY = 1,
  localparam int LEVEL_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  TYPE                    w_data,
  output logic                   r_valid,
  input  logic                   r_ready,
  output TYPE                    r_data,
  output logic [LEVEL_WIDTH-1:0] level,
  output logic                   almost_full,
  output logic                   almost_empty
);

  localparam int PTR_WIDTH = $clog2(DEPTH);

  localparam logic [PTR_WIDTH-1:0]   PtrMax  = PTR_WIDTH'(DEPTH - 1);
  localparam logic [LEVEL_WIDTH-1:0] LvlFull = LEVEL_WIDTH'(DEPTH);
  localparam logic [LEVEL_WIDTH-1:0] LvlAf   = LEVEL_WIDTH'(ALMOST_FULL);
  localparam logic [LEVEL_WIDTH-1:0] LvlAe   = LEVEL_WIDTH'(ALMOST_EMPTY);

  // Elaboration-time parameter checks
  if (DEPTH < 2) begin : g_chk_depth
    $fatal(1, "sync_fifo: DEPTH must be >= 2");
  end
  if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_chk_af
    $fatal(1, "sync_fifo: ALMOST_FULL must be in 1..DEPTH");
  end
  if (ALMOST_EMPTY < 0 || ALMOST_EMPTY > DEPTH - 1) begin : g_chk_ae
    $fatal(1, "sync_fifo: ALMOST_EMPTY must be in 0..DEPTH-1");
  end

  TYPE                    mem_q [DEPTH];
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LEVEL_WIDTH-1:0] count_q, count_d;
  logic                   af_q, af_d;
  logic                   ae_q, ae_d;

  logic empty;
  logic wr_fire;
  logic rd_fire;
  logic bypass;
  logic push;
  logic pop;

  assign empty = (count_q == '0);

  // Handshake outputs. w_ready depends only on state and flush, never on r_ready.
  always_comb begin
    w_ready = !flush && (count_q != LvlFull);
`ifdef SYNC_FIFO_PASSTHROUGH_EN
    r_valid = !flush && (!empty || w_valid);
    r_data  = empty ? w_data : mem_q[rd_ptr_q];
`else
    r_valid = !flush && !empty;
    r_data  = mem_q[rd_ptr_q];
`endif
  end

  assign wr_fire = w_valid && w_ready;
  assign rd_fire = r_valid && r_ready;

`ifdef SYNC_FIFO_PASSTHROUGH_EN
  // Empty FIFO with both sides firing: the word goes straight through.
  assign bypass = empty && wr_fire && rd_fire;
`else
  assign bypass = 1'b0;
`endif

  assign push = wr_fire && !bypass;
  assign pop  = rd_fire && !bypass;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = (wr_ptr_q == PtrMax) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PtrMax) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    // Flags follow count_d so they line up with level on every cycle.
    af_d = (count_d >= LvlAf);
    ae_d = (count_d <= LvlAe);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
    end
  end

  // Storage is not reset; entries are only observable once written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= w_data;
    end
  end

  assign level        = count_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Testbench for sync_fifo (DEPTH=5, ALMOST_FULL=4, ALMOST_EMPTY=1, 8-bit data).
// The driver pushes every word it expects the FIFO to accept onto a queue; a
// monitor on the falling edge checks handshake outputs, level and flags against
// the queue occupancy and pops/compares on every read transfer.
module tb_sync_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int LW    = $clog2(DEPTH + 1);
`ifdef SYNC_FIFO_PASSTHROUGH_EN
  localparam bit PT = 1'b1;
`else
  localparam bit PT = 1'b0;
`endif

  logic          clk     = 1'b0;
  logic          rstn    = 1'b0;
  logic          flush   = 1'b0;
  logic          w_valid = 1'b0;
  logic          r_ready = 1'b0;
  logic [DW-1:0] w_data  = '0;
  logic          w_ready;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          almost_empty;

  sync_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .ALMOST_FULL (AF),
    .ALMOST_EMPTY(AE)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_data      (w_data),
    .r_valid     (r_valid),
    .r_ready     (r_ready),
    .r_data      (r_data),
    .level       (level),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  bit            wr_pushed  = 1'b0;
  bit            pend_valid = 1'b0;
  logic [DW-1:0] pend_data  = '0;
  bit            hold_prev  = 1'b0;
  logic [DW-1:0] hold_data  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares outputs against the queue-based model each cycle.
  always @(negedge clk) begin
    int            pre;
    bit            e_rv;
    bit            e_wr;
    logic [DW-1:0] exp_d;
    pre  = exp_q.size() - int'(wr_pushed);
    e_wr = !flush && (pre != DEPTH);
    e_rv = !flush && ((pre != 0) || (PT && w_valid));
    chk("level", 32'(level), 32'(pre));
    chk("w_ready", 32'(w_ready), 32'(e_wr));
    chk("r_valid", 32'(r_valid), 32'(e_rv));
    chk("almost_full", 32'(almost_full), 32'(pre >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(pre <= AE));
    if (e_rv && r_ready) begin
      if (exp_q.size() == 0) begin
        chk("read_unexpected", 32'(r_data), 32'hFFFF_FFFF);
      end else begin
        exp_d = exp_q.pop_front();
        chk("r_data", 32'(r_data), 32'(exp_d));
      end
    end
    if (flush) exp_q.delete();
    if (!rstn) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && !flush) begin
        chk("hold_w_valid", 32'(w_valid), 32'd1);
        chk("hold_w_data", 32'(w_data), 32'(hold_data));
      end
      hold_prev = w_valid && !w_ready && !flush;
      hold_data = w_data;
    end
    wr_pushed = 1'b0;
  end

  // One cycle of stimulus. A refused write is re-offered unchanged until taken.
  task automatic step(input bit wv, input logic [DW-1:0] wd, input bit rr, input bit fl,
                      output bit acc);
    @(posedge clk);
    #1;
    if (pend_valid && !fl) begin
      wv = 1'b1;
      wd = pend_data;
    end
    w_valid = wv;
    w_data  = wd;
    r_ready = rr;
    flush   = fl;
    acc = wv && !fl && (exp_q.size() < DEPTH);
    if (acc) begin
      exp_q.push_back(wd);
      wr_pushed = 1'b1;
    end
    pend_valid = wv && !acc && !fl;
    pend_data  = wd;
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 20 && (exp_q.size() > 0 || pend_valid); i++) step(0, '0, 1, 0, acc);
    step(0, '0, 0, 0, acc);
    @(negedge clk);
    #1;
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit wv;
    bit rr;
    int sent;

    // Reset state, observed by the monitor while rstn is low
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Fill to full, offer a sixth word, then drain in order
    for (int i = 0; i < 5; i++) step(1, 8'(8'h10 + i), 0, 0, acc);
    step(1, 8'h15, 0, 0, acc);
    chk("sixth_refused", 32'(acc), 32'd0);
    step(1, 8'h15, 0, 0, acc);
    drain();

    // Random wrap stream 0x00..0x0B
    sent = 0;
    for (int cyc = 0; cyc < 400 && (sent < 12 || exp_q.size() > 0 || pend_valid); cyc++) begin
      wv = (sent < 12) && ($urandom_range(0, 1) == 1);
      rr = ($urandom_range(0, 1) == 1);
      step(wv, 8'(sent), rr, 0, acc);
      if (acc) sent++;
    end
    drain();
    chk("wrap_sent", 32'(sent), 32'd12);

    // Simultaneous transfer at level 3
    for (int i = 0; i < 3; i++) step(1, 8'(8'h30 + i), 0, 0, acc);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h33 + i), 1, 0, acc);

    // Flush at level 3 with a competing write
    step(1, 8'hEE, 0, 1, acc);
    chk("flush_write_refused", 32'(acc), 32'd0);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, acc);

    // Asynchronous reset mid-operation at level 4
    for (int i = 0; i < 4; i++) step(1, 8'(8'h40 + i), 0, 0, acc);
    @(posedge clk);
    #1;
    rstn       = 1'b0;
    w_valid    = 1'b0;
    r_ready    = 1'b0;
    flush      = 1'b0;
    exp_q.delete();
    wr_pushed  = 1'b0;
    pend_valid = 1'b0;
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_r_valid", 32'(r_valid), 32'd0);
    chk("rst_w_ready", 32'(w_ready), 32'd1);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    step(1, 8'h5A, 0, 0, acc);
    step(0, '0, 1, 0, acc);
    drain();

    // Empty FIFO, write and read offered together
    step(1, 8'hAB, 1, 0, acc);
    #2;
    chk("pt_r_valid", 32'(r_valid), 32'(PT));
    chk("pt_level", 32'(level), 32'd0);
    step(0, '0, 1, 0, acc);
    #2;
    chk("pt_next_level", 32'(level), 32'(!PT));
    chk("pt_next_r_valid", 32'(r_valid), 32'(!PT));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
